// File: rtl/decode_pkg.sv
// Shared RV32I decode constants: opcodes, ALU operation and write-back select encodings.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  // alt selects SUB/SRA; callers pass 0 where funct7[5] has no meaning.
  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_reg_file.sv
// 32x32 register file, two read ports, one write port, write-to-read bypass, x0 hardwired to 0.
module decode_reg_file
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic        i_we,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data
);

  logic [31:0] r_regs [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_rd != 5'd0)) begin
      r_regs[i_rd] <= i_wdata;
    end
  end

  always_comb begin
    o_rs1_data = '0;
    o_rs2_data = '0;
    if (i_rs1 != 5'd0) o_rs1_data = (i_we && (i_rd == i_rs1)) ? i_wdata : r_regs[i_rs1];
    if (i_rs2 != 5'd0) o_rs2_data = (i_we && (i_rd == i_rs2)) ? i_wdata : r_regs[i_rs2];
  end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: IF/ID register, register file, immediate generation, control decode
// and branch/jump resolution with redirect back to fetch.
module decode
  import decode_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_ENC,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction_f,
  input  logic [31:0] pc_f,
  input  logic        mem_valid_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        branch_d,
  output logic [31:0] branch_next_addr_d,
  output logic        valid_d,
  output logic [31:0] pc_d,
  output logic [4:0]  rs1_d,
  output logic [4:0]  rs2_d,
  output logic [4:0]  rd_d,
  output logic [31:0] rs1_data_d,
  output logic [31:0] rs2_data_d,
  output logic [31:0] imm_d,
  output logic [3:0]  alu_op_d,
  output logic        alu_src_a_pc_d,
  output logic        alu_src_b_imm_d,
  output logic        mem_read_d,
  output logic        mem_write_d,
  output logic [2:0]  funct3_d,
  output logic [1:0]  wb_sel_d,
  output logic        reg_write_d,
  output logic        illegal_d
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_imm;
  alu_op_e     w_alu_op;
  wb_sel_e     w_wb_sel;
  logic        w_src_a_pc, w_src_b_imm, w_mem_read, w_mem_write, w_reg_write;
  logic        w_legal, w_jal, w_jalr, w_bxx, w_taken, w_ok, w_branch;

  // IF/ID register: a taken redirect squashes the sequential instruction behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP_INSTR;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
    end else if (flush_d) begin
      r_instr <= NOP_INSTR;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
    end else if (!stall_d) begin
      if (w_branch || !mem_valid_f) begin
        r_instr <= NOP_INSTR;
        r_pc    <= RESET_PC;
        r_valid <= 1'b0;
      end else begin
        r_instr <= instruction_f;
        r_pc    <= pc_f;
        r_valid <= 1'b1;
      end
    end
  end

  assign w_opc = r_instr[6:0];
  assign w_f3  = r_instr[14:12];
  assign w_f7  = r_instr[31:25];
  assign rs1_d = r_instr[19:15];
  assign rs2_d = r_instr[24:20];

  assign w_imm_i = {{20{r_instr[31]}}, r_instr[31:20]};
  assign w_imm_s = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
  assign w_imm_b = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
  assign w_imm_u = {r_instr[31:12], 12'b0};
  assign w_imm_j = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};

  decode_reg_file u_reg_file (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rs1      (rs1_d),
    .i_rs2      (rs2_d),
    .i_we       (wb_we),
    .i_rd       (wb_rd),
    .i_wdata    (wb_data),
    .o_rs1_data (rs1_data_d),
    .o_rs2_data (rs2_data_d)
  );

  always_comb begin
    w_imm       = '0;
    w_alu_op    = ALU_ADD;
    w_wb_sel    = WB_ALU;
    w_src_a_pc  = 1'b0;
    w_src_b_imm = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_legal     = 1'b1;
    w_jal       = 1'b0;
    w_jalr      = 1'b0;
    w_bxx       = 1'b0;
    case (w_opc)
      OPC_LUI: begin
        w_imm = w_imm_u; w_alu_op = ALU_PASSB; w_src_b_imm = 1'b1; w_reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        w_imm = w_imm_u; w_src_a_pc = 1'b1; w_src_b_imm = 1'b1; w_reg_write = 1'b1;
      end
      OPC_JAL: begin
        w_imm = w_imm_j; w_jal = 1'b1; w_wb_sel = WB_PC4; w_reg_write = 1'b1;
      end
      OPC_JALR: begin
        w_imm = w_imm_i; w_legal = (w_f3 == 3'b000); w_jalr = 1'b1;
        w_wb_sel = WB_PC4; w_src_b_imm = 1'b1; w_reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        w_imm = w_imm_b; w_bxx = 1'b1; w_alu_op = ALU_SUB;
        w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
      end
      OPC_LOAD: begin
        w_imm = w_imm_i; w_mem_read = 1'b1; w_wb_sel = WB_MEM; w_src_b_imm = 1'b1; w_reg_write = 1'b1;
        w_legal = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
      end
      OPC_STORE: begin
        w_imm = w_imm_s; w_mem_write = 1'b1; w_src_b_imm = 1'b1;
        w_legal = (w_f3 < 3'b011);
      end
      OPC_OPIMM: begin
        w_imm = w_imm_i; w_src_b_imm = 1'b1; w_reg_write = 1'b1;
        w_alu_op = alu_from_funct(w_f3, (w_f3 == 3'b101) && w_f7[5]);
        if (w_f3 == 3'b001) w_legal = (w_f7 == 7'b0000000);
        if (w_f3 == 3'b101) w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
      end
      OPC_OP: begin
        w_reg_write = 1'b1;
        w_alu_op = alu_from_funct(w_f3, w_f7[5]);
        w_legal = (w_f7 == 7'b0000000) ||
                  ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (w_f3)
      3'b000:  w_taken = (rs1_data_d == rs2_data_d);
      3'b001:  w_taken = (rs1_data_d != rs2_data_d);
      3'b100:  w_taken = ($signed(rs1_data_d) <  $signed(rs2_data_d));
      3'b101:  w_taken = ($signed(rs1_data_d) >= $signed(rs2_data_d));
      3'b110:  w_taken = (rs1_data_d <  rs2_data_d);
      3'b111:  w_taken = (rs1_data_d >= rs2_data_d);
      default: w_taken = 1'b0;
    endcase
  end

  // Illegal encodings are decoded but never allowed to write, access memory or redirect.
  assign w_ok     = r_valid && w_legal;
  assign w_branch = w_ok && !stall_d && !flush_d && (w_jal || w_jalr || (w_bxx && w_taken));

  assign branch_d           = w_branch;
  assign branch_next_addr_d = w_jalr ? ((rs1_data_d + w_imm) & ~32'd1) : (r_pc + w_imm);
  assign valid_d            = r_valid;
  assign pc_d               = r_pc;
  assign imm_d              = w_imm;
  assign alu_op_d           = w_alu_op;
  assign alu_src_a_pc_d     = w_src_a_pc;
  assign alu_src_b_imm_d    = w_src_b_imm;
  assign funct3_d           = w_f3;
  assign wb_sel_d           = w_wb_sel;
  assign reg_write_d        = w_ok && w_reg_write;
  assign mem_read_d         = w_ok && w_mem_read;
  assign mem_write_d        = w_ok && w_mem_write;
  assign illegal_d          = r_valid && !w_legal;
  assign rd_d               = reg_write_d ? r_instr[11:7] : 5'd0;

endmodule

// File: tb/tb_decode.sv
// Bench for the decode stage: directed scenarios followed by randomized instructions checked
// against a field-level reference model of the register file and instruction semantics.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instruction_f = 32'h0000_0013;
  logic [31:0] pc_f = 32'h0;
  logic        mem_valid_f = 1'b0;
  logic        stall_d = 1'b0;
  logic        flush_d = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'h0;

  logic        branch_d, valid_d, alu_src_a_pc_d, alu_src_b_imm_d;
  logic        mem_read_d, mem_write_d, reg_write_d, illegal_d;
  logic [31:0] branch_next_addr_d, pc_d, rs1_data_d, rs2_data_d, imm_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [3:0]  alu_op_d;
  logic [2:0]  funct3_d;
  logic [1:0]  wb_sel_d;

  decode dut (
    .clk(clk), .rst_n(rst_n), .instruction_f(instruction_f), .pc_f(pc_f),
    .mem_valid_f(mem_valid_f), .stall_d(stall_d), .flush_d(flush_d),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .branch_d(branch_d), .branch_next_addr_d(branch_next_addr_d), .valid_d(valid_d),
    .pc_d(pc_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .rs1_data_d(rs1_data_d), .rs2_data_d(rs2_data_d), .imm_d(imm_d), .alu_op_d(alu_op_d),
    .alu_src_a_pc_d(alu_src_a_pc_d), .alu_src_b_imm_d(alu_src_b_imm_d),
    .mem_read_d(mem_read_d), .mem_write_d(mem_write_d), .funct3_d(funct3_d),
    .wb_sel_d(wb_sel_d), .reg_write_d(reg_write_d), .illegal_d(illegal_d)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mreg [32];

  // OP-IMM / OP variants: funct3, funct7 and the ALU code each one must select.
  int oi_f3  [9]  = '{0, 2, 3, 4, 6, 7, 1, 5, 5};
  int oi_alu [9]  = '{0, 3, 4, 5, 8, 9, 2, 6, 7};
  int op_f3  [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  int op_f7  [10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
  int ld_f3  [5]  = '{0, 1, 2, 4, 5};
  int br_f3  [6]  = '{0, 1, 4, 5, 6, 7};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (wb_we && (wb_rd != 5'd0)) mreg[wb_rd] = wb_data;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (wb_we && (wb_rd == r)) return wb_data;
    return mreg[r];
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    logic [31:0] v;
    v = imm;
    return {v[11:5], rs2, rs1, f3, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
  endfunction

  task automatic present(input logic [31:0] ins, input logic [31:0] pc);
    instruction_f = ins;
    pc_f          = pc;
    mem_valid_f   = 1'b1;
  endtask

  localparam logic [31:0] BEQ_X1_X2_8 = 32'h0020_8463;
  localparam logic [31:0] ADDI_X1_5   = 32'h0050_0093;

  int          kind, sub, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  f3;
  logic [19:0] u20;
  logic [31:0] ins, pc, a, b, e_imm, e_tgt;
  logic [3:0]  e_alu;
  logic [1:0]  e_wb;
  logic        e_rw, e_mr, e_mw, e_sa, e_sb, e_br, ck_imm, ck_alu, ck_f3, use1, use2;

  initial begin
    clear_model();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_d), 32'd0);
    chk("rst_branch", 32'(branch_d), 32'd0);
    chk("rst_reg_write", 32'(reg_write_d), 32'd0);
    chk("rst_pc", pc_d, 32'd0);
    rst_n = 1'b1;

    present(enc_r(7'd0, 5'd31, 5'd17, 3'd0, 5'd0), 32'h4);
    tick();
    chk("rst_x17", rs1_data_d, 32'd0);
    chk("rst_x31", rs2_data_d, 32'd0);

    present(ADDI_X1_5, 32'h10);
    tick();
    chk("addi_valid", 32'(valid_d), 32'd1);
    chk("addi_pc", pc_d, 32'h10);
    chk("addi_imm", imm_d, 32'd5);
    chk("addi_rd", 32'(rd_d), 32'd1);
    chk("addi_alu", 32'(alu_op_d), 32'd0);
    chk("addi_rw", 32'(reg_write_d), 32'd1);

    mem_valid_f = 1'b0; wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd7;
    tick();
    chk("nomem_valid", 32'(valid_d), 32'd0);
    wb_rd = 5'd2;
    tick();
    wb_we = 1'b0;

    present(BEQ_X1_X2_8, 32'h20);
    tick();
    chk("beq_branch", 32'(branch_d), 32'd1);
    chk("beq_target", branch_next_addr_d, 32'h28);
    present(ADDI_X1_5, 32'h24);
    tick();
    chk("beq_squash", 32'(valid_d), 32'd0);

    present(BEQ_X1_X2_8, 32'h20);
    tick();
    stall_d = 1'b1;
    #1;
    chk("stall_branch", 32'(branch_d), 32'd0);
    present(ADDI_X1_5, 32'h24);
    tick();
    chk("stall_hold_pc", pc_d, 32'h20);
    chk("stall_hold_branch", 32'(branch_d), 32'd0);
    stall_d = 1'b0;
    #1;
    chk("release_branch", 32'(branch_d), 32'd1);
    tick();
    chk("release_squash", 32'(valid_d), 32'd0);
    chk("release_once", 32'(branch_d), 32'd0);

    present(BEQ_X1_X2_8, 32'h20);
    tick();
    flush_d = 1'b1;
    #1;
    chk("flush_branch", 32'(branch_d), 32'd0);
    stall_d = 1'b1;
    tick();
    chk("flush_stall_valid", 32'(valid_d), 32'd0);
    chk("flush_stall_pc", pc_d, 32'd0);
    flush_d = 1'b0; stall_d = 1'b0;

    present(enc_r(7'd0, 5'd0, 5'd3, 3'd0, 5'd4), 32'h30);
    tick();
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
    #1;
    chk("bypass_rs1", rs1_data_d, 32'hDEAD_BEEF);
    chk("bypass_rd", 32'(rd_d), 32'd4);
    tick();
    wb_we = 1'b0;
    #1;
    chk("written_x3", rs1_data_d, 32'hDEAD_BEEF);

    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    present(enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd5), 32'h34);
    tick();
    chk("x0_bypass", rs1_data_d, 32'd0);
    tick();
    wb_we = 1'b0;
    #1;
    chk("x0_stored", rs1_data_d, 32'd0);

    present(32'h0000_007F, 32'h40);
    tick();
    chk("illegal_flag", 32'(illegal_d), 32'd1);
    chk("illegal_rw", 32'(reg_write_d), 32'd0);
    chk("illegal_mem", 32'({mem_read_d, mem_write_d, branch_d}), 32'd0);
    present(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3), 32'h44);
    tick();
    chk("mul_illegal", 32'(illegal_d), 32'd1);
    chk("mul_rw", 32'(reg_write_d), 32'd0);
    present(32'h0000_0073, 32'h48);
    tick();
    chk("ecall_legal", 32'(illegal_d), 32'd0);
    chk("ecall_rw", 32'(reg_write_d), 32'd0);

    present(BEQ_X1_X2_8, 32'h20);
    tick();
    chk("pre_reset_branch", 32'(branch_d), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_branch", 32'(branch_d), 32'd0);
    chk("async_rst_valid", 32'(valid_d), 32'd0);
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    present(enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd0), 32'h50);
    tick();
    chk("rst_cleared_x1", rs1_data_d, 32'd0);

    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 8);
      rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
      pc = $urandom & 32'hFFFF_FFFC;
      e_rw = 0; e_mr = 0; e_mw = 0; e_sa = 0; e_sb = 1; e_br = 0; e_wb = 2'd0; e_alu = 4'd0;
      ck_imm = 1; ck_alu = 1; ck_f3 = 1; use1 = 1; use2 = 0; f3 = 3'd0; imm = 0; ins = 32'h13;
      case (kind)
        0: begin
          sub = $urandom_range(0, 8);
          f3 = 3'(oi_f3[sub]); e_alu = 4'(oi_alu[sub]); e_rw = 1;
          if (sub < 6) imm = int'($urandom_range(0, 4095)) - 2048;
          else imm = int'($urandom_range(0, 31)) + ((sub == 8) ? 32'h400 : 0);
          ins = enc_i(imm, rs1, f3, rd, 7'b0010011);
        end
        1: begin
          sub = $urandom_range(0, 9);
          f3 = 3'(op_f3[sub]); e_alu = 4'(sub); e_rw = 1; e_sb = 0; ck_imm = 0; use2 = 1;
          ins = enc_r(7'(op_f7[sub]), rs2, rs1, f3, rd);
        end
        2, 3: begin
          u20 = 20'($urandom); imm = int'({u20, 12'b0});
          e_rw = 1; use1 = 0; ck_f3 = 0;
          e_alu = (kind == 2) ? 4'd10 : 4'd0; e_sa = (kind == 3);
          ins = {u20, rd, (kind == 2) ? 7'b0110111 : 7'b0010111};
        end
        4: begin
          f3 = 3'(ld_f3[$urandom_range(0, 4)]); imm = int'($urandom_range(0, 4095)) - 2048;
          e_rw = 1; e_mr = 1; e_wb = 2'd1;
          ins = enc_i(imm, rs1, f3, rd, 7'b0000011);
        end
        5: begin
          f3 = 3'($urandom_range(0, 2)); imm = int'($urandom_range(0, 4095)) - 2048;
          e_mw = 1; use2 = 1;
          ins = enc_s(imm, rs2, rs1, f3);
        end
        6: begin
          f3 = 3'(br_f3[$urandom_range(0, 5)]);
          imm = int'($urandom_range(0, 4095)) * 2 - 4096;
          if ($urandom_range(0, 2) == 0) rs2 = rs1;
          e_sb = 0; ck_alu = 0; use2 = 1;
          ins = enc_b(imm, rs2, rs1, f3);
        end
        7: begin
          imm = int'($urandom_range(0, 1048575)) * 2 - 1048576;
          e_rw = 1; e_wb = 2'd2; e_sb = 0; ck_alu = 0; use1 = 0; ck_f3 = 0;
          ins = enc_j(imm, rd);
        end
        default: begin
          imm = int'($urandom_range(0, 4095)) - 2048;
          e_rw = 1; e_wb = 2'd2;
          ins = enc_i(imm, rs1, 3'd0, rd, 7'b1100111);
        end
      endcase
      e_imm = imm;
      present(ins, pc);
      tick();
      wb_we = ($urandom_range(0, 3) != 0); wb_rd = 5'($urandom); wb_data = $urandom;
      #1;
      a = ref_read(rs1);
      b = ref_read(rs2);
      e_tgt = pc + e_imm;
      if (kind == 7) e_br = 1;
      if (kind == 8) begin e_br = 1; e_tgt = (a + e_imm) & ~32'd1; end
      if (kind == 6) begin
        case (f3)
          3'd0: e_br = (a == b);
          3'd1: e_br = (a != b);
          3'd4: e_br = ($signed(a) < $signed(b));
          3'd5: e_br = ($signed(a) >= $signed(b));
          3'd6: e_br = (a < b);
          default: e_br = (a >= b);
        endcase
      end
      chk("rnd_valid", 32'(valid_d), 32'd1);
      chk("rnd_pc", pc_d, pc);
      chk("rnd_rd", 32'(rd_d), 32'(e_rw ? rd : 5'd0));
      chk("rnd_rw", 32'(reg_write_d), 32'(e_rw));
      chk("rnd_mem", 32'({mem_read_d, mem_write_d}), 32'({e_mr, e_mw}));
      chk("rnd_wb_sel", 32'(wb_sel_d), 32'(e_wb));
      chk("rnd_src", 32'({alu_src_a_pc_d, alu_src_b_imm_d}), 32'({e_sa, e_sb}));
      chk("rnd_illegal", 32'(illegal_d), 32'd0);
      chk("rnd_branch", 32'(branch_d), 32'(e_br));
      if (ck_imm) chk("rnd_imm", imm_d, e_imm);
      if (ck_alu) chk("rnd_alu", 32'(alu_op_d), 32'(e_alu));
      if (ck_f3)  chk("rnd_funct3", 32'(funct3_d), 32'(f3));
      if (use1)   chk("rnd_rs1_data", rs1_data_d, a);
      if (use2)   chk("rnd_rs2_data", rs2_data_d, b);
      if (e_br) begin
        chk("rnd_target", branch_next_addr_d, e_tgt);
        present($urandom, pc + 32'd4);
        tick();
        chk("rnd_squash", 32'(valid_d), 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
